// File: rtl/alu_scheduler.sv
// alu_scheduler: two-requester round-robin front end for a shared
// combinational ALU. One operation is in flight at a time. The operands are
// registered onto the ALU, held for EXEC_CYCLES cycles, and then the result
// and flags are captured. They are returned over a response handshake tagged
// with the requester id.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   reqN_valid / reqN_ready         request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_sel        operands (signed) and ALU select
//   alu_a, alu_b, alu_sel           registered operands/select to the ALU
//   alu_out, alu_carry..alu_sign    ALU result and flags
//   resp_valid / resp_ready         response handshake
//   resp_id, resp_data, resp_flags  requester id, result, {c,v,p,z,s}
//   op_count0, op_count1            saturating completed-response counters
module alu_scheduler #(
    parameter int W           = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_sel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_out,
    input  logic         alu_carry,
    input  logic         alu_overflow,
    input  logic         alu_parity,
    input  logic         alu_zero,
    input  logic         alu_sign,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic [4:0]   resp_flags,
    output logic [7:0]   op_count0,
    output logic [7:0]   op_count1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t       state_q, state_d;
    logic [3:0]   exec_cnt_q;
    logic         cur_id_q;
    logic         last_id_q;
    logic [W-1:0] alu_a_q, alu_b_q;
    logic [2:0]   alu_sel_q;
    logic [W-1:0] resp_data_q;
    logic [4:0]   resp_flags_q;
    logic [7:0]   opcnt0_q, opcnt1_q;
    logic         grant0, grant1;
    logic         accept, exec_done, resp_hs;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // On contention the requester not served last wins; last_id resets to 1
    // so requester 0 wins the first contention.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id_q);
        grant1 = req1_valid & (~req0_valid | ~last_id_q);
    end

    assign accept    = req0_ready | req1_ready;
    assign exec_done = (state_q == S_EXEC) && (exec_cnt_q == 4'd0);
    assign resp_hs   = resp_valid & resp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_EXEC;
            S_EXEC:  if (exec_done) state_d = S_RESP;
            S_RESP:  if (resp_hs)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = (state_q == S_IDLE) & grant0;
        req1_ready = (state_q == S_IDLE) & grant1;
        resp_valid = (state_q == S_RESP);
    end

    // Operand, capture and counter registers. Every one of them clears on
    // reset, so an abandoned op leaves nothing visible behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt_q   <= 4'd0;
            cur_id_q     <= 1'b0;
            last_id_q    <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 3'd0;
            resp_data_q  <= '0;
            resp_flags_q <= 5'd0;
            opcnt0_q     <= 8'd0;
            opcnt1_q     <= 8'd0;
        end else begin
            if (accept) begin
                alu_a_q    <= grant1 ? req1_a   : req0_a;
                alu_b_q    <= grant1 ? req1_b   : req0_b;
                alu_sel_q  <= grant1 ? req1_sel : req0_sel;
                cur_id_q   <= grant1;
                exec_cnt_q <= EXEC_LOAD;
            end
            if (state_q == S_EXEC) begin
                if (exec_cnt_q == 4'd0) begin
                    resp_data_q  <= alu_out;
                    resp_flags_q <= {alu_carry, alu_overflow, alu_parity,
                                     alu_zero, alu_sign};
                end else begin
                    exec_cnt_q <= exec_cnt_q - 4'd1;
                end
            end
            if (resp_hs) begin
                last_id_q <= cur_id_q;
                if (cur_id_q) opcnt1_q <= sat_inc(opcnt1_q);
                else          opcnt0_q <= sat_inc(opcnt0_q);
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign resp_id    = cur_id_q;
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;
    assign op_count0  = opcnt0_q;
    assign op_count1  = opcnt1_q;

endmodule
